// File: rtl/pc_update_unit.sv
// pc_update_unit: program counter sequencing with stall and held redirect
module pc_update_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BUSYWAIT,
  input  logic        JUMP,
  input  logic        BRANCH,
  input  logic        BRANCH_NE,
  input  logic        ZERO,
  input  logic [7:0]  OFFSET,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic [31:0] INSTR_COUNT,
  output logic        REDIRECT_PENDING
);
  typedef enum logic [1:0] {RUN, STALL, STALL_REDIR} state_t;
  state_t      state_q;
  logic [31:0] pc_q, cnt_q, tgt_q;
  logic        pend_q;
  logic        take;
  logic [31:0] target;
  assign take     = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO);
  assign PC_PLUS4 = pc_q + 32'd4;
  assign target   = PC_PLUS4 + {{22{OFFSET[7]}}, OFFSET, 2'b00};
  // advance when not stalled, otherwise hold and remember the first taken redirect
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      pc_q    <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
    end else if (!BUSYWAIT) begin
      pc_q    <= (state_q == STALL_REDIR) ? tgt_q : (take ? target : PC_PLUS4);
      cnt_q   <= cnt_q + 32'd1;
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else if (state_q != STALL_REDIR) begin
      state_q <= take ? STALL_REDIR : STALL;
      pend_q  <= take;
      if (take) tgt_q <= target;
    end
  end
  assign PC               = pc_q;
  assign INSTR_COUNT      = cnt_q;
  assign REDIRECT_PENDING = pend_q;
endmodule
